// File: rtl/var_shift_pkg.sv
// Shared types and helpers for the pipelined variable shifter (var_shift_pipe).
package var_shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROL = 2'b11
  } sh_op_e;

  function automatic int sh_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

  // Number of binary shift stages for a given data width (at least one).
  function automatic int sh_stages(input int width);
    return (width < 2) ? 1 : sh_clog2(width);
  endfunction

  localparam int SH_DEF_WIDTH  = 8;
  localparam int SH_DEF_STAGES = sh_stages(SH_DEF_WIDTH);

endpackage

// File: rtl/var_shift_pipe_if.sv
// Handshake bundle between operand issue, var_shift_pipe and the result consumer.
interface var_shift_pipe_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 8,
  parameter int TAGW  = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AW-1:0]    in_amt;
  logic [1:0]       in_op;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAGW-1:0]  out_tag;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_ovf
  );

endinterface

// File: rtl/var_shift_stage.sv
// One registered binary shift stage: shifts by 2**K when amount bit K is set.
// Rotate support is compiled in only with VAR_SHIFT_ROTATE_EN.
module var_shift_stage
  import var_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAGW  = 4,
  parameter int L     = 3,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_advance,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  input  logic [L-1:0]     i_amt,
  input  sh_op_e           i_op,
  input  logic             i_fill,
  input  logic             i_ovf,
  input  logic [TAGW-1:0]  i_tag,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data,
  output logic [L-1:0]     o_amt,
  output sh_op_e           o_op,
  output logic             o_fill,
  output logic             o_ovf,
  output logic [TAGW-1:0]  o_tag
);

  localparam int               S    = 1 << K;
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] w_shifted;

  always_comb begin
    w_shifted = i_data;
    if (i_amt[K]) begin
      case (i_op)
        SH_LSL:  w_shifted = i_data << S;
        SH_LSR:  w_shifted = i_data >> S;
        SH_ASR:  w_shifted = (i_data >> S) | (i_fill ? ~(ONES >> S) : '0);
`ifdef VAR_SHIFT_ROTATE_EN
        SH_ROL:  w_shifted = (i_data << S) | (i_data >> (WIDTH - S));
`else
        SH_ROL:  w_shifted = i_data << S;
`endif
        default: w_shifted = i_data;
      endcase
    end
  end

  // Stage register: everything moves together on advance, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld  <= 1'b0;
      o_data <= '0;
      o_amt  <= '0;
      o_op   <= SH_LSL;
      o_fill <= 1'b0;
      o_ovf  <= 1'b0;
      o_tag  <= '0;
    end else if (i_advance) begin
      o_vld  <= i_vld;
      o_data <= w_shifted;
      o_amt  <= i_amt;
      o_op   <= i_op;
      o_fill <= i_fill;
      o_ovf  <= i_ovf;
      o_tag  <= i_tag;
    end
  end

endmodule

// File: rtl/var_shift_pipe.sv
// Pipelined variable shifter (LSL/LSR/ASR, plus ROL when VAR_SHIFT_ROTATE_EN is
// defined; otherwise op 11 behaves as LSL). One register per binary shift stage.
module var_shift_pipe
  import var_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = 8,
  parameter int TAGW  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  var_shift_pipe_if.slave bus
);

  localparam int L = sh_stages(WIDTH);

  logic             w_advance;
  sh_op_e           w_s0_op;
  logic             w_s0_ovf;
  logic             w_s0_fill;
  logic             w_s0_sat;
  logic [WIDTH-1:0] w_s0_data;
  logic [L-1:0]     w_s0_amt;

  logic             w_vld  [L];
  logic [WIDTH-1:0] w_data [L];
  logic [L-1:0]     w_amt  [L];
  sh_op_e           w_op   [L];
  logic             w_fill [L];
  logic             w_ovf  [L];
  logic [TAGW-1:0]  w_tag  [L];

  // Global stall: the whole pipe moves only when the output slot can drain.
  assign w_advance    = !w_vld[L-1] || bus.out_ready;
  assign bus.in_ready = w_advance;

  // Out-of-range non-rotate shifts saturate by preloading the fill pattern
  // and shifting by zero, so later stages need no overflow awareness.
  always_comb begin
    w_s0_op = sh_op_e'(bus.in_op);
`ifndef VAR_SHIFT_ROTATE_EN
    if (w_s0_op == SH_ROL) w_s0_op = SH_LSL;
`endif
    w_s0_ovf  = ({1'b0, bus.in_amt} >= (AW+1)'(WIDTH));
    w_s0_fill = (w_s0_op == SH_ASR) && bus.in_data[WIDTH-1];
    w_s0_sat  = w_s0_ovf && (w_s0_op != SH_ROL);
    w_s0_data = w_s0_sat ? {WIDTH{w_s0_fill}} : bus.in_data;
    w_s0_amt  = w_s0_sat ? '0 : bus.in_amt[L-1:0];
  end

  for (genvar k = 0; k < L; k++) begin : g_stage
    logic             w_i_vld;
    logic [WIDTH-1:0] w_i_data;
    logic [L-1:0]     w_i_amt;
    sh_op_e           w_i_op;
    logic             w_i_fill;
    logic             w_i_ovf;
    logic [TAGW-1:0]  w_i_tag;

    if (k == 0) begin : g_src_in
      assign w_i_vld  = bus.in_valid;
      assign w_i_data = w_s0_data;
      assign w_i_amt  = w_s0_amt;
      assign w_i_op   = w_s0_op;
      assign w_i_fill = w_s0_fill;
      assign w_i_ovf  = w_s0_ovf;
      assign w_i_tag  = bus.in_tag;
    end else begin : g_src_prev
      assign w_i_vld  = w_vld[k-1];
      assign w_i_data = w_data[k-1];
      assign w_i_amt  = w_amt[k-1];
      assign w_i_op   = w_op[k-1];
      assign w_i_fill = w_fill[k-1];
      assign w_i_ovf  = w_ovf[k-1];
      assign w_i_tag  = w_tag[k-1];
    end

    var_shift_stage #(
      .WIDTH (WIDTH),
      .TAGW  (TAGW),
      .L     (L),
      .K     (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_advance (w_advance),
      .i_vld     (w_i_vld),
      .i_data    (w_i_data),
      .i_amt     (w_i_amt),
      .i_op      (w_i_op),
      .i_fill    (w_i_fill),
      .i_ovf     (w_i_ovf),
      .i_tag     (w_i_tag),
      .o_vld     (w_vld[k]),
      .o_data    (w_data[k]),
      .o_amt     (w_amt[k]),
      .o_op      (w_op[k]),
      .o_fill    (w_fill[k]),
      .o_ovf     (w_ovf[k]),
      .o_tag     (w_tag[k])
    );
  end

  assign bus.out_valid = w_vld[L-1];
  assign bus.out_data  = w_data[L-1];
  assign bus.out_tag   = w_tag[L-1];
  assign bus.out_ovf   = w_ovf[L-1];

endmodule

// File: doc/var_shift_pipe.md
# var_shift_pipe

Pipelined, parametrised variable shifter: the successor to the combinational `a << b` datapath. It accepts one operand, shift amount and operation per cycle over a valid/ready handshake. It supports logical left, logical right, arithmetic right and (optionally) rotate left, and returns the result after a fixed latency of one register per binary shift stage. It sits between operand-issue logic and any result consumer able to apply backpressure.

## Interface
Parameters:
- `WIDTH`, 8: data width; power of two, 2..64.
- `AW`, 8: shift-amount width; must satisfy AW ≥ log2(WIDTH).
- `TAGW`, 4: width of an opaque sideband tag carried alongside the data.

Ports (all signals single clock domain; clock and reset first):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: input transaction present.
- `in_ready` out 1: block can accept an input this cycle.
- `in_data` in WIDTH: operand.
- `in_amt` in AW: shift amount, unsigned.
- `in_op` in 2: operation select. 00 LSL, 01 LSR, 10 ASR, 11 ROL.
- `in_tag` in TAGW: sideband, returned unchanged.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out WIDTH: result.
- `out_tag` out TAGW: tag of this result.
- `out_ovf` out 1: original `in_amt` ≥ WIDTH.

## Operation
- Pipeline depth: L = log2(WIDTH) stages. Stage k conditionally shifts by 2^k, selected by bit k of the effective amount.
- Stage 0 register captures the following:
  - data, op, tag;
  - effective amount;
  - ovf = (in_amt ≥ WIDTH);
  - fill bit = in_data[WIDTH-1] for ASR, else 0.
- Effective amount:
  - ROL: in_amt mod WIDTH (low bits).
  - Other ops with ovf: forced to produce all-fill at the output.
  - Other ops without ovf: in_amt.
- Saturation rules for ovf:
  - LSL and LSR produce 0.
  - ASR produces all copies of the sign bit.
  - ROL is unaffected; `out_ovf` is still reported.
- LSL and LSR shift in zeros. ASR shifts in the captured fill bit. ROL wraps MSB→LSB.
- Handshake:
  - `advance` = !out_valid | out_ready.
  - `in_ready` = advance. This is combinational, with no dependence on `in_valid`.
  - When advance is high, every stage register and its valid bit load from the previous stage. Stage 0 valid loads `in_valid`.
  - When advance is low, all stages hold. This is a global stall; bubbles are not compressed.
- Input and output are accepted on the same cycle whenever out_ready = 1. Full throughput is one result per cycle.
- `out_*` are the last-stage registers. They remain stable while out_valid & !out_ready.

## Timing
- Reset (rst_n low, asynchronous): all valid bits 0, out_valid 0, out_data 0, out_tag 0, out_ovf 0. in_ready = 1 immediately.
- Release of rst_n is synchronised by the integrating level. The first accept can occur on the first edge with rst_n high.
- Latency: an input accepted at edge n appears with out_valid = 1 after edge n+L-1, provided no stall occurs. For WIDTH = 8, results are visible two cycles after the accepting edge, so three registers span the path.
- A stall of s cycles adds exactly s cycles to every in-flight transaction.
- Reset asserted mid-stream discards all in-flight transactions; none emerge after reset release.
- in_valid with !in_ready: the source must hold its inputs. The block samples nothing.

## Configuration
- `VAR_SHIFT_ROTATE_EN` defined: op 11 performs rotate-left as above.
- Not defined: rotate logic is omitted, and op 11 is treated as LSL, including the ovf saturation rule. No other behaviour changes.

## Structure
- Package `var_shift_pkg`:
  - op enum (`SH_LSL`, `SH_LSR`, `SH_ASR`, `SH_ROL`);
  - function `sh_clog2`;
  - localparam helper for L.
- Sub-module `var_shift_stage`:
  - parameter K (shift distance 2^K);
  - one registered stage with valid, amount, op, fill, ovf and tag pipelined through;
  - instantiated L times with a generate loop in the top.
- The top contains only stage-0 capture logic, the advance signal and output wiring.

## Test plan
All scenarios use WIDTH = 8.
1. LSL sweep: in_data 8'h01, in_amt 0..7, back-to-back with out_ready = 1 → out_data 8'h01, 02, 04 … 80 on consecutive cycles, first result after 3 register stages. Also 8'ha5 LSL 7 → 8'h80 and 8'ha5 LSL 1 → 8'h4a.
2. Right shifts and overflow:
   - 8'ha5 LSR 2 → 8'h29;
   - 8'ha5 ASR 2 → 8'he9;
   - 8'ha5 ASR 9 → 8'hff with out_ovf = 1;
   - 8'h25 ASR 200 → 8'h00 with out_ovf = 1;
   - 8'ha5 LSL 8 → 8'h00 with out_ovf = 1.
3. Rotate (macro on): 8'ha5 ROL 1 → 8'h4b; ROL 9 → 8'h4b with out_ovf = 1. Macro off: 8'ha5 op 11, amount 1 → 8'h4a.
4. Backpressure: stream 5 tagged inputs, drop out_ready for 3 cycles mid-stream → in_ready is low exactly while out_valid & !out_ready. Outputs hold stable, all 5 tags arrive in order with no loss or duplication.
5. Reset mid-flight: 3 transactions in flight, pulse rst_n low between edges → out_valid = 0 and in_ready = 1 immediately. No stale result appears after release.
6. Random: 10k random op/amount/data with random out_ready, checked against a reference model → zero mismatches and order preserved by tag.
